game_end_of_game_timer: RTL and testbench



---
 rtl/game_end_of_game_timer_pkg.sv | 15 +
 rtl/game_tick_prescaler.sv | 28 ++
 rtl/game_end_of_game_timer.sv | 110 +++++++++++
 tb/tb_game_end_of_game_timer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/game_end_of_game_timer_pkg.sv
// Shared game configuration: FSM state encoding and default timing for the board clock.
// Consumed by game_end_of_game_timer (optional key skip: GAME_END_TIMER_KEY_SKIP_EN).
package game_end_of_game_timer_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // 50 MHz board clock: one tick per second.
    localparam int DEFAULT_PRESCALE       = 50000000;
    localparam int DEFAULT_DURATION_TICKS = 2;
    localparam int DEFAULT_BLINK_TICKS    = 1;
    localparam int DEFAULT_SKIP_MIN_TICKS = 1;

endpackage

// File: rtl/game_tick_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE enabled cycles; clear restarts the count.
// Also used by the sprite update-rate logic.
module game_tick_prescaler #(
    parameter int PRESCALE = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int             CW   = $clog2(PRESCALE + 1);
    localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count_reg;

    assign tick = enable && !clear && (count_reg == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/game_end_of_game_timer.sv
// End-of-game timer answering the master FSM's start strobe with running/done/blink.
// Define GAME_END_TIMER_KEY_SKIP_EN to add the key port that cuts the run short.
module game_end_of_game_timer
    import game_end_of_game_timer_pkg::*;
#(
    parameter int PRESCALE       = DEFAULT_PRESCALE,
    parameter int DURATION_TICKS = DEFAULT_DURATION_TICKS,
    parameter int BLINK_TICKS    = DEFAULT_BLINK_TICKS,
    parameter int SKIP_MIN_TICKS = DEFAULT_SKIP_MIN_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic won,
`ifdef GAME_END_TIMER_KEY_SKIP_EN
    input  logic key,
`endif
    output logic running,
    output logic done,
    output logic won_latched,
    output logic blink
);

    localparam int            TW        = $clog2(DURATION_TICKS + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(DURATION_TICKS - 1);
    localparam int            BW        = $clog2(BLINK_TICKS + 1);
    localparam logic [BW-1:0] LAST_BLNK = BW'(BLINK_TICKS - 1);

    logic [1:0]    state_reg, state_next;
    logic [TW-1:0] tick_cnt_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          phase_reg;
    logic          won_reg;
    logic          tick;
    logic          in_run;
    logic          expire;
    logic          skip;

    assign in_run = (state_reg == RUN);

    // Held clear outside RUN so the count always starts from zero on a fresh run.
    game_tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (start || !in_run),
        .enable (in_run),
        .tick   (tick)
    );

    assign expire = in_run && tick && (tick_cnt_reg == LAST_TICK);

`ifdef GAME_END_TIMER_KEY_SKIP_EN
    assign skip = in_run && key && (int'(tick_cnt_reg) >= SKIP_MIN_TICKS);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN: begin
                if (start)
                    state_next = RUN;
                else if (expire || skip)
                    state_next = DONE;
            end
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            tick_cnt_reg  <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            won_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                tick_cnt_reg  <= '0;
                blink_cnt_reg <= '0;
                phase_reg     <= 1'b1;
                won_reg       <= won;
            end else if (state_next != RUN) begin
                tick_cnt_reg  <= '0;
                blink_cnt_reg <= '0;
            end else if (tick) begin
                tick_cnt_reg <= tick_cnt_reg + 1'b1;
                if (blink_cnt_reg == LAST_BLNK) begin
                    blink_cnt_reg <= '0;
                    phase_reg     <= ~phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign running     = in_run;
    assign done        = (state_reg == DONE);
    assign won_latched = won_reg;
    // A lost game shows a steady display; a won game flashes.
    assign blink       = in_run && (won_reg ? phase_reg : 1'b1);

endmodule

// File: tb/tb_game_end_of_game_timer.sv
// Randomized bench for game_end_of_game_timer against a cycle-count reference model.
// Honours GAME_END_TIMER_KEY_SKIP_EN when defined for the build.
module tb_game_end_of_game_timer;

    localparam int P  = 4;
    localparam int D  = 3;
    localparam int B  = 1;
    localparam int SM = 1;

    logic clk = 1'b0;
    logic reset, start, won, key;
    logic running, done, won_latched, blink;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: cycles of running left, cycles already run.
    int  m_left = 0;
    int  m_elapsed = 0;
    bit  m_done = 0;
    bit  m_won = 0;

    always #5 clk = ~clk;

    game_end_of_game_timer #(
        .PRESCALE       (P),
        .DURATION_TICKS (D),
        .BLINK_TICKS    (B),
        .SKIP_MIN_TICKS (SM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .won         (won),
`ifdef GAME_END_TIMER_KEY_SKIP_EN
        .key         (key),
`endif
        .running     (running),
        .done        (done),
        .won_latched (won_latched),
        .blink       (blink)
    );

    task automatic check_val(input string tag, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    function automatic void model_step(input bit r, input bit s, input bit w, input bit k);
        bit skip_now;
        skip_now = 0;
`ifdef GAME_END_TIMER_KEY_SKIP_EN
        skip_now = k && (m_left > 0) && ((m_elapsed / P) >= SM);
`endif
        if (r) begin
            m_left = 0; m_elapsed = 0; m_done = 0; m_won = 0;
        end else if (s) begin
            m_left = P * D; m_elapsed = 0; m_done = 0; m_won = w;
        end else if (skip_now) begin
            m_left = 0; m_elapsed = 0; m_done = 1;
        end else if (m_left > 0) begin
            m_left--;
            m_elapsed++;
            m_done = (m_left == 0);
            if (m_left == 0) m_elapsed = 0;
        end else begin
            m_done = 0;
        end
    endfunction

    task automatic step(input bit r, input bit s, input bit w, input bit k);
        bit exp_blink;
        @(negedge clk);
        reset = r; start = s; won = w; key = k;
        @(posedge clk);
        model_step(r, s, w, k);
        #1;
        exp_blink = (m_left > 0) && (!m_won || (((m_elapsed / (P * B)) % 2) == 0));
        $display("cyc r=%0b s=%0b w=%0b k=%0b -> run=%0b done=%0b wl=%0b blink=%0b",
                 r, s, w, k, running, done, won_latched, blink);
        check_val("running", running, m_left > 0);
        check_val("done", done, m_done);
        check_val("won_latched", won_latched, m_won);
        check_val("blink", blink, exp_blink);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; won = 1'b0; key = 1'b0;
        repeat (3) step(1, 0, 0, 0);
        // Lost game: start, full run, done.
        step(0, 1, 0, 0);
        repeat (15) step(0, 0, 0, 0);
        // Won game with retrigger 8 cycles later.
        step(0, 1, 1, 0);
        repeat (7) step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        repeat (15) step(0, 0, 0, 0);
        // Reset mid-run, then nothing should pulse.
        step(0, 1, 1, 0);
        repeat (4) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (15) step(0, 0, 0, 0);
        // Start exactly in the DONE cycle.
        step(0, 1, 1, 0);
        repeat (12) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (15) step(0, 0, 0, 0);
        // Key presses early (ignored) and later (skip when enabled).
        step(0, 1, 1, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (12) step(0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 24) == 0),
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 9) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
